fsynth: RTL and testbench
=========================

FSYNTH -- requirements
Module: fsynth

Interface
REQ-001 SHALL have parameter F_CLK, default 40000, meaning clock frequency in hundreds of Hz.
REQ-002 SHALL have parameter ACC_W, default 17, meaning accumulator width; it SHALL satisfy 2^ACC_W > F_CLK-1 + 2*(2^14-1).
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port f_in, input, 14, meaning requested output frequency in hundreds of Hz; this is the same encoding fcounter reports.
REQ-006 SHALL have port f_load, input, 1, meaning a one-cycle strobe that captures f_in as the pending frequency.
REQ-007 SHALL have port burst_len, input, 16, meaning the number of full output cycles to generate; 0 means continuous.
REQ-008 SHALL have port start, input, 1, meaning a one-cycle strobe that begins generation; it is honoured only in IDLE.
REQ-009 SHALL have port stop, input, 1, meaning a one-cycle strobe that requests a cycle-aligned stop.
REQ-010 SHALL have port sig, output, 1, meaning the generated square wave.
REQ-011 SHALL have port running, output, 1, meaning the state is not IDLE.
REQ-012 SHALL have port done, output, 1, meaning a one-cycle pulse on return to IDLE.
REQ-013 SHALL have port cyc_cnt, output, 16, meaning the number of completed output cycles since start.

Function
REQ-014 SHALL use states IDLE, RUN and STOPPING.
REQ-015 SHALL, on start in IDLE: clear acc and cyc_cnt, drive sig=0, load f_act from the pending frequency, latch burst_len, and enter RUN on the next edge.
REQ-016 SHALL, in RUN and STOPPING each clk, compute s = acc + 2*f_act; if s >= F_CLK then acc <= s - F_CLK and sig toggles, otherwise acc <= s.
REQ-017 SHALL give an output frequency of exactly f_act*100 Hz on average, with no cumulative drift.
REQ-018 SHALL produce at most one toggle per clk; this is guaranteed because 2*16383 < F_CLK.
REQ-019 SHALL, for f_in=4000, produce a toggle every 5 clk, giving a 10-clk period.
REQ-020 SHALL, for f_in=400, produce a toggle every 50 clk.
REQ-021 SHALL apply a pending f_load to f_act only on a falling toggle of sig (1->0), keeping the output glitch-free; acc is not cleared at that point.
REQ-022 SHALL, if f_load and start coincide in IDLE, use the new f_in immediately.
REQ-023 SHALL, on each falling toggle, increment cyc_cnt, saturating at 16'hFFFF.
REQ-024 SHALL, when burst_len != 0 and cyc_cnt reaches burst_len on a falling toggle, go to IDLE and pulse done.
REQ-025 SHALL, on stop in RUN, enter STOPPING; STOPPING continues until the next falling toggle, then goes to IDLE and pulses done.
REQ-026 SHALL, when f_act=0, hold sig low with no toggles.
REQ-027 SHALL, on stop while f_act=0, go to IDLE on the next edge and pulse done.
REQ-028 SHALL give stop priority over start when both arrive in the same cycle; start is ignored outside IDLE.
REQ-029 SHALL treat a burst completion coinciding with stop as a single IDLE transition with a single done pulse.
REQ-030 SHALL hold sig=0 in IDLE; cyc_cnt holds its final value until the next start.
REQ-031 SHALL keep the pending frequency register live in all states; the last f_load before the applying event wins.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force state=IDLE, sig=0, running=0, done=0, acc=0, cyc_cnt=0, f_act=0, pending=0 and burst=0.
REQ-033 SHALL, on reset assertion mid-burst, stop sig immediately with no done pulse.
REQ-034 SHALL release reset synchronously to clk (external synchroniser); the first start is honoured on the first edge after release.

Structure
REQ-035 SHALL place F_CLK, the default ACC_W, the 14-bit frequency width and the state enumeration in the shared package fcounter_pkg, also used by fcounter.
REQ-036 SHALL implement the accumulator, compare and subtract of REQ-016 as sub-module fsynth_nco (ports: clk, rst_n, clr, en, f_act, toggle).
REQ-037 SHALL keep the state machine, cycle counter and frequency staging in fsynth.

Verification
REQ-038 SHALL cover: f_in=4000, burst_len=0, start -> sig period exactly 10 clk from the first rise; fcounter loopback reports 4000.
REQ-039 SHALL cover: f_in=1739, burst_len=100, start -> done after exactly 100 falling toggles; cyc_cnt=100; sig=0 after done; total time within 1 clk of 100*40000/1739 clk.
REQ-040 SHALL cover: run at 400, f_load 2000 while sig is high -> old period finishes; new 20-clk period begins at the falling toggle; no short pulse.
REQ-041 SHALL cover: stop 3 clk after a rise at f_in=4000 -> sig falls 2 clk later; done pulses once; running=0.
REQ-042 SHALL cover: f_in=0, start -> sig stays 0 for 1000 clk; stop -> IDLE next edge with done.
REQ-043 SHALL cover: rst_n low for 1 clk mid-burst at f_in=16383 -> all outputs 0 with no done; a new start behaves as a fresh burst.

Source files
------------

// File: rtl/fcounter_pkg.sv
// fcounter_pkg: constants and state type shared by fsynth and fcounter
package fcounter_pkg;
  localparam int F_CLK_DEF = 40000;
  localparam int ACC_W_DEF = 17;
  localparam int FREQ_W = 14;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
endpackage

// File: rtl/fsynth_nco.sv
// fsynth_nco: phase accumulator that strobes toggle whenever the accumulated phase crosses F_CLK
// ports: clk, rst_n (async, active low), clr (zero acc), en (advance), f_act (frequency, 100 Hz units), toggle (comb)
module fsynth_nco
  import fcounter_pkg::*;
#(
  parameter int F_CLK = F_CLK_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [FREQ_W-1:0] f_act,
  output logic              toggle
);
  localparam logic [ACC_W-1:0] FC = ACC_W'(F_CLK);
  logic [ACC_W-1:0] acc, s;
  // 2*f_act per clock against F_CLK yields f_act*100 Hz full cycles, remainder carried so no drift
  always_comb begin
    s = acc + ACC_W'({f_act, 1'b0});
    toggle = en && s >= FC;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else acc <= clr ? '0 : !en ? acc : toggle ? s - FC : s;
endmodule

// File: rtl/fsynth.sv
// fsynth: square-wave frequency synthesizer with burst count and cycle-aligned stop
// ports: clk, rst_n (async, active low); f_in/f_load stage a pending frequency; burst_len (0 = continuous);
//        start/stop strobes; sig square wave; running (not IDLE); done pulse; cyc_cnt completed cycles
module fsynth
  import fcounter_pkg::*;
#(
  parameter int F_CLK = F_CLK_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FREQ_W-1:0] f_in,
  input  logic              f_load,
  input  logic [15:0]       burst_len,
  input  logic              start,
  input  logic              stop,
  output logic              sig,
  output logic              running,
  output logic              done,
  output logic [15:0]       cyc_cnt
);
  state_t state, state_nxt;
  logic [FREQ_W-1:0] pend, pend_nxt, f_act;
  logic [15:0] burst, cyc_inc;
  logic go, active, toggle, fall, stopping, fin;
  fsynth_nco #(.F_CLK(F_CLK), .ACC_W(ACC_W)) u_nco (
    .clk(clk), .rst_n(rst_n), .clr(go), .en(active), .f_act(f_act), .toggle(toggle)
  );
  assign running = active;
  always_comb begin
    pend_nxt = f_load ? f_in : pend;
    active = state != IDLE;
    go = state == IDLE && start && !stop;
    fall = toggle && sig;
    cyc_inc = cyc_cnt == 16'hFFFF ? cyc_cnt : cyc_cnt + 16'd1;
    stopping = state == STOPPING || (state == RUN && stop);
    // a stop coinciding with the falling toggle or burst end collapses into one IDLE transition
    fin = active && ((fall && (stopping || (burst != 0 && cyc_inc == burst))) || (stopping && f_act == 0));
    state_nxt = go ? RUN : fin ? IDLE : stopping ? STOPPING : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sig <= 1'b0;
      done <= 1'b0;
      cyc_cnt <= '0;
      f_act <= '0;
      pend <= '0;
      burst <= '0;
    end else begin
      sig <= go ? 1'b0 : toggle ? ~sig : sig;
      done <= fin;
      cyc_cnt <= go ? '0 : fall ? cyc_inc : cyc_cnt;
      // new frequency only at the falling edge so no runt pulse appears
      f_act <= (go || fall) ? pend_nxt : f_act;
      pend <= pend_nxt;
      burst <= go ? burst_len : burst;
    end
endmodule

// File: tb/tb_fsynth.sv
// tb_fsynth: directed and randomized checks of fsynth against a behavioural reference model
module tb_fsynth;
  localparam int FCLK = 40000;
  logic clk = 0, rst_n = 0;
  logic [13:0] f_in = 0;
  logic f_load = 0, start = 0, stop = 0;
  logic [15:0] burst_len = 0;
  logic sig, running, done;
  logic [15:0] cyc_cnt;
  int total = 0, bad = 0, ncyc = 0, nrise = 0, nfall = 0, ndone = 0;
  int last_rise = 0, prev_rise = 0, last_fall = 0;
  int t0, r, d0, n0, f0, fl;
  int m_acc, m_f, m_pend, m_burst, m_cyc;
  bit m_run, m_sig, m_done, m_req, psig;

  fsynth dut (
    .clk(clk), .rst_n(rst_n), .f_in(f_in), .f_load(f_load), .burst_len(burst_len),
    .start(start), .stop(stop), .sig(sig), .running(running), .done(done), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_acc = 0; m_f = 0; m_pend = 0; m_burst = 0; m_cyc = 0;
    m_run = 0; m_sig = 0; m_done = 0; m_req = 0; psig = 0;
  endtask

  // one clock of the generator: phase advances by 2*f per clock, wraps at FCLK with a half-cycle flip
  task automatic model_edge;
    int pn, s, fold;
    bit tog, fin;
    pn = f_load ? int'(f_in) : m_pend;
    fin = 0;
    if (!m_run) begin
      if (start && !stop) begin
        m_acc = 0; m_cyc = 0; m_sig = 0; m_f = pn; m_burst = burst_len; m_run = 1; m_req = 0;
      end
    end else begin
      m_req = m_req || stop;
      fold = m_f;
      s = m_acc + 2 * m_f;
      tog = s >= FCLK;
      m_acc = tog ? s - FCLK : s;
      if (tog && m_sig) begin
        m_cyc = (m_cyc == 65535) ? m_cyc : m_cyc + 1;
        m_f = pn;
        fin = m_req || (m_burst != 0 && m_cyc == m_burst);
      end
      if (tog) m_sig = !m_sig;
      if (m_req && fold == 0) fin = 1;
      if (fin) m_run = 0;
    end
    m_done = fin;
    m_pend = pn;
  endtask

  task automatic tick;
    @(posedge clk);
    model_edge;
    #1;
    start = 0; stop = 0; f_load = 0;
    ncyc++;
    chk("sig", sig, m_sig);
    chk("running", running, m_run);
    chk("done", done, m_done);
    chk("cyc_cnt", cyc_cnt, m_cyc);
    if (sig && !psig) begin prev_rise = last_rise; last_rise = ncyc; nrise++; end
    if (!sig && psig) begin last_fall = ncyc; nfall++; end
    if (done) ndone++;
    psig = sig;
  endtask

  task automatic go(int f, int bl);
    f_in = 14'(f); f_load = 1; burst_len = 16'(bl); start = 1;
    tick;
  endtask

  task automatic wait_rises(int n, int bound);
    int tgt = nrise + n;
    for (int k = 0; k < bound && nrise < tgt; k++) tick;
    chk("rise_timeout", nrise >= tgt, 1);
  endtask

  task automatic wait_falls(int n, int bound);
    int tgt = nfall + n;
    for (int k = 0; k < bound && nfall < tgt; k++) tick;
    chk("fall_timeout", nfall >= tgt, 1);
  endtask

  task automatic wait_done(int bound);
    int tgt = ndone + 1;
    for (int k = 0; k < bound && ndone < tgt; k++) tick;
    chk("done_timeout", ndone >= tgt, 1);
  endtask

  initial begin
    model_reset;
    #3;
    chk("rst_sig", sig, 0);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_cyc", cyc_cnt, 0);
    @(negedge clk);
    rst_n = 1;

    // 4000 continuous: toggle every 5 clk, 10-clk period
    go(4000, 0);
    t0 = ncyc;
    wait_rises(1, 20);
    chk("first_rise", last_rise - t0, 5);
    wait_rises(1, 20);
    chk("period_4000", last_rise - prev_rise, 10);
    // stop 3 clk after a rise: fall 2 clk later, one done
    r = last_rise; d0 = ndone;
    tick; tick; stop = 1; tick; tick; tick;
    chk("stop_fall", last_fall - r, 5);
    chk("stop_done", ndone - d0, 1);
    chk("stop_running", running, 0);
    repeat (10) tick;
    chk("stop_done_once", ndone - d0, 1);

    // burst of 100 at 1739
    go(1739, 100);
    t0 = ncyc; f0 = nfall;
    wait_done(3000);
    chk("burst_time", ncyc - t0, (200 * FCLK + 2 * 1739 - 1) / (2 * 1739));
    chk("burst_falls", nfall - f0, 100);
    chk("burst_cyc", cyc_cnt, 100);
    chk("burst_sig", sig, 0);
    repeat (5) tick;
    chk("burst_cyc_hold", cyc_cnt, 100);

    // retune 400 -> 2000 while high
    go(400, 0);
    wait_rises(1, 60);
    r = last_rise;
    repeat (20) tick;
    f_in = 2000; f_load = 1;
    tick;
    wait_falls(1, 60);
    chk("old_high", last_fall - r, 50);
    fl = last_fall;
    wait_rises(1, 30);
    chk("new_low", last_rise - fl, 10);
    wait_falls(1, 30);
    chk("new_high", last_fall - last_rise, 10);
    stop = 1;
    tick;
    wait_done(40);

    // f = 0 holds low, stop ends next edge
    go(0, 0);
    n0 = nrise;
    repeat (1000) tick;
    chk("zero_no_rise", nrise - n0, 0);
    stop = 1;
    tick;
    chk("zero_done", done, 1);
    chk("zero_running", running, 0);

    // async reset mid-burst
    go(16383, 50);
    repeat (30) tick;
    #2;
    rst_n = 0;
    #1;
    model_reset;
    d0 = ndone;
    chk("mid_rst_sig", sig, 0);
    chk("mid_rst_running", running, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_cyc", cyc_cnt, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_done_hold", done, 0);
    @(negedge clk);
    rst_n = 1;
    go(16383, 5);
    wait_done(200);
    chk("fresh_cyc", cyc_cnt, 5);
    chk("fresh_done_once", ndone - d0, 1);

    // randomized runs checked per clock by the model
    for (int rnd = 0; rnd < 10; rnd++) begin
      go(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1000, 16383)), int'($urandom_range(0, 12)));
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 39) == 0) begin f_in = 14'($urandom_range(1000, 16383)); f_load = 1; end
        if ($urandom_range(0, 149) == 0) stop = 1;
        else if ($urandom_range(0, 99) == 0) begin
          start = 1; burst_len = 16'($urandom_range(0, 12));
        end
        tick;
      end
      stop = 1;
      tick;
      for (int k = 0; k < 100 && running; k++) tick;
      chk("rand_idle", running, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
